// File: rtl/memoria_pkg.sv
// Shared types and constants for the memoria_dp_sync dual-port RAM.
package memoria_pkg;

    typedef enum logic {INIT, RUN} state_e;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    localparam int unsigned PRIO_A = 0;
    localparam int unsigned PRIO_B = 1;

endpackage

// File: rtl/memoria_dp_sync_if.sv
// Bus bundle for both memoria_dp_sync ports plus the collision status outputs.
interface memoria_dp_sync_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4,
    parameter int unsigned CW = 8
);
    logic          reqA;
    logic          rwA;
    logic [AW-1:0] AddrA;
    logic [DW-1:0] DataInA;
    logic          readyA;
    logic [DW-1:0] DataOutA;
    logic          validA;

    logic          reqB;
    logic          rwB;
    logic [AW-1:0] AddrB;
    logic [DW-1:0] DataInB;
    logic          readyB;
    logic [DW-1:0] DataOutB;
    logic          validB;

    logic          collision;
    logic [CW-1:0] coll_count;

    modport master (
        output reqA, rwA, AddrA, DataInA, reqB, rwB, AddrB, DataInB,
        input  readyA, DataOutA, validA, readyB, DataOutB, validB, collision, coll_count
    );

    modport slave (
        input  reqA, rwA, AddrA, DataInA, reqB, rwB, AddrB, DataInB,
        output readyA, DataOutA, validA, readyB, DataOutB, validB, collision, coll_count
    );

endinterface

// File: rtl/memoria_clr_fsm.sv
// INIT/RUN sequencer: sweeps every address to zero after reset, then raises ready.
module memoria_clr_fsm
    import memoria_pkg::*;
#(
    parameter int unsigned AW = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          ready_o
);

    localparam logic [AW-1:0] PtrMax = '1;

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic          ready_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    // Last clear write: ready goes high together with the RUN transition.
                    if (ptr_q == PtrMax) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: ready_q <= 1'b1;
            endcase
        end
    end

    assign clr_we_o   = (state_q == INIT) & ~reset_i;
    assign clr_addr_o = ptr_q;
    assign ready_o    = ready_q;

endmodule

// File: rtl/memoria_dp_sync.sv
// True dual-port synchronous RAM with handshake, registered reads and collision arbitration.
// Optional macro MEM_BYPASS_EN selects write-first forwarding for read/write same-address.
module memoria_dp_sync
    import memoria_pkg::*;
#(
    parameter int unsigned AW   = 3,
    parameter int unsigned DW   = 4,
    parameter int unsigned PRIO = 0,
    parameter int unsigned CW   = 8
) (
    input logic              clk,
    input logic              reset,
    memoria_dp_sync_if.slave bus
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam bit AWins = (PRIO == PRIO_A);

    logic [DW-1:0] mem_q [2**AW];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          ready;

    logic          acc_a, acc_b;
    logic          wr_a, wr_b, rd_a, rd_b;
    logic          coll;
    logic          keep_a, keep_b;
    logic [DW-1:0] rdata_a, rdata_b;

    logic [DW-1:0] dout_a_q, dout_b_q;
    logic          valid_a_q, valid_b_q;
    logic          coll_q;
    logic [CW-1:0] coll_cnt_q;

    memoria_clr_fsm #(
        .AW (AW)
    ) u_clr_fsm (
        .clk_i      (clk),
        .reset_i    (reset),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .ready_o    (ready)
    );

    // Ready is registered, so it may still read high during the first reset cycle.
    assign acc_a = bus.reqA & ready & ~reset;
    assign acc_b = bus.reqB & ready & ~reset;
    assign wr_a  = acc_a & (bus.rwA == WR);
    assign wr_b  = acc_b & (bus.rwB == WR);
    assign rd_a  = acc_a & (bus.rwA == RD);
    assign rd_b  = acc_b & (bus.rwB == RD);
    assign coll  = wr_a & wr_b & (bus.AddrA == bus.AddrB);

    assign keep_a = wr_a & ~(coll & ~AWins);
    assign keep_b = wr_b & ~(coll & AWins);

    always_comb begin
        rdata_a = mem_q[bus.AddrA];
        rdata_b = mem_q[bus.AddrB];
`ifdef MEM_BYPASS_EN
        if (wr_b && (bus.AddrB == bus.AddrA)) rdata_a = bus.DataInB;
        if (wr_a && (bus.AddrA == bus.AddrB)) rdata_b = bus.DataInA;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (clr_we) mem_q[clr_addr] <= '0;
        if (keep_a) mem_q[bus.AddrA] <= bus.DataInA;
        if (keep_b) mem_q[bus.AddrB] <= bus.DataInB;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            valid_a_q <= rd_a;
            valid_b_q <= rd_b;
            if (rd_a) dout_a_q <= rdata_a;
            if (rd_b) dout_b_q <= rdata_b;
            coll_q <= coll;
            if (coll && (coll_cnt_q != CntMax)) coll_cnt_q <= coll_cnt_q + 1'b1;
        end
    end

    assign bus.readyA     = ready;
    assign bus.readyB     = ready;
    assign bus.DataOutA   = dout_a_q;
    assign bus.DataOutB   = dout_b_q;
    assign bus.validA     = valid_a_q;
    assign bus.validB     = valid_b_q;
    assign bus.collision  = coll_q;
    assign bus.coll_count = coll_cnt_q;

endmodule

// File: tb/tb_memoria_dp_sync.sv
// Directed bench: three instances (PRIO=0, PRIO=1, CW=2) share one stimulus stream.
module tb_memoria_dp_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       reqA, rwA, reqB, rwB;
    logic [2:0] AddrA, AddrB;
    logic [3:0] DataInA, DataInB;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memoria_dp_sync_if #(.AW(3), .DW(4), .CW(8)) if0 ();
    memoria_dp_sync_if #(.AW(3), .DW(4), .CW(8)) if1 ();
    memoria_dp_sync_if #(.AW(3), .DW(4), .CW(2)) if2 ();

    assign {if0.reqA, if0.rwA, if0.AddrA, if0.DataInA} = {reqA, rwA, AddrA, DataInA};
    assign {if0.reqB, if0.rwB, if0.AddrB, if0.DataInB} = {reqB, rwB, AddrB, DataInB};
    assign {if1.reqA, if1.rwA, if1.AddrA, if1.DataInA} = {reqA, rwA, AddrA, DataInA};
    assign {if1.reqB, if1.rwB, if1.AddrB, if1.DataInB} = {reqB, rwB, AddrB, DataInB};
    assign {if2.reqA, if2.rwA, if2.AddrA, if2.DataInA} = {reqA, rwA, AddrA, DataInA};
    assign {if2.reqB, if2.rwB, if2.AddrB, if2.DataInB} = {reqB, rwB, AddrB, DataInB};

    memoria_dp_sync #(.AW(3), .DW(4), .PRIO(0), .CW(8)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    memoria_dp_sync #(.AW(3), .DW(4), .PRIO(1), .CW(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    memoria_dp_sync #(.AW(3), .DW(4), .PRIO(0), .CW(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reqA = 1'b0; rwA = 1'b1; AddrA = '0; DataInA = '0;
        reqB = 1'b0; rwB = 1'b1; AddrB = '0; DataInB = '0;
    endtask

    // Releases reset and checks ready stays low for exactly the 8-cycle sweep.
    task automatic release_and_sweep(input string tag);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_eq($sformatf("%s_readyA_%0d", tag, i), 32'(if0.readyA), (i == 8) ? 1 : 0);
            check_eq($sformatf("%s_readyB_%0d", tag, i), 32'(if1.readyB), (i == 8) ? 1 : 0);
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            reqA = 1'b1; rwA = 1'b1; AddrA = 3'(i);
            reqB = 1'b1; rwB = 1'b1; AddrB = 3'(7 - i);
            step();
            check_eq($sformatf("%s_validA_%0d", tag, i), 32'(if0.validA), 1);
            check_eq($sformatf("%s_doutA_%0d", tag, i), 32'(if0.DataOutA), 0);
            check_eq($sformatf("%s_validB_%0d", tag, i), 32'(if1.validB), 1);
            check_eq($sformatf("%s_doutB_%0d", tag, i), 32'(if1.DataOutB), 0);
        end
        idle();
        step();
        check_eq({tag, "_validA_end"}, 32'(if0.validA), 0);
    endtask

    initial begin
        logic [3:0] rw_exp;
        idle();
        reset = 1'b1;
        step();
        step();
        check_eq("rst_readyA", 32'(if0.readyA), 0);
        check_eq("rst_validA", 32'(if0.validA), 0);
        check_eq("rst_doutB", 32'(if0.DataOutB), 0);
        check_eq("rst_coll", 32'(if0.collision), 0);
        check_eq("rst_count", 32'(if0.coll_count), 0);

        release_and_sweep("init");
        read_all_zero("zero");

        // A writes 9 @2, B reads it back next cycle.
        reqA = 1'b1; rwA = 1'b0; AddrA = 3'd2; DataInA = 4'b1001;
        step();
        check_eq("wr_no_valid", 32'(if0.validA), 0);
        idle();
        reqB = 1'b1; rwB = 1'b1; AddrB = 3'd2;
        step();
        check_eq("xrd_validB", 32'(if0.validB), 1);
        check_eq("xrd_doutB", 32'(if0.DataOutB), 4'b1001);
        idle();
        step();
        check_eq("xrd_validB_low", 32'(if0.validB), 0);
        check_eq("xrd_doutB_hold", 32'(if0.DataOutB), 4'b1001);

        // Write-write collision on address 2.
        reqA = 1'b1; rwA = 1'b0; AddrA = 3'd2; DataInA = 4'b1001;
        reqB = 1'b1; rwB = 1'b0; AddrB = 3'd2; DataInB = 4'b1010;
        step();
        check_eq("coll_pulse0", 32'(if0.collision), 1);
        check_eq("coll_pulse1", 32'(if1.collision), 1);
        check_eq("coll_cnt0", 32'(if0.coll_count), 1);
        check_eq("coll_cnt1", 32'(if1.coll_count), 1);
        idle();
        reqA = 1'b1; rwA = 1'b1; AddrA = 3'd2;
        step();
        check_eq("coll_off", 32'(if0.collision), 0);
        check_eq("coll_rd_prioA", 32'(if0.DataOutA), 4'b1001);
        check_eq("coll_rd_prioB", 32'(if1.DataOutA), 4'b1010);

        // Distinct-address writes both land.
        idle();
        reqA = 1'b1; rwA = 1'b0; AddrA = 3'd0; DataInA = 4'b0001;
        reqB = 1'b1; rwB = 1'b0; AddrB = 3'd1; DataInB = 4'b0010;
        step();
        check_eq("diff_no_coll", 32'(if0.collision), 0);
        rwA = 1'b1; rwB = 1'b1;
        step();
        check_eq("diff_rdA", 32'(if0.DataOutA), 4'b0001);
        check_eq("diff_rdB", 32'(if0.DataOutB), 4'b0010);

        // Read on A and write on B to address 5 in the same cycle.
        idle();
        reqA = 1'b1; rwA = 1'b0; AddrA = 3'd5; DataInA = 4'b0011;
        step();
        rwA = 1'b1;
        reqB = 1'b1; rwB = 1'b0; AddrB = 3'd5; DataInB = 4'b1100;
        step();
`ifdef MEM_BYPASS_EN
        rw_exp = 4'b1100;
`else
        rw_exp = 4'b0011;
`endif
        check_eq("rw_same_doutA", 32'(if0.DataOutA), 32'(rw_exp));
        check_eq("rw_same_coll", 32'(if0.collision), 0);
        idle();
        reqA = 1'b1; rwA = 1'b1; AddrA = 3'd5;
        step();
        check_eq("rw_after_doutA", 32'(if0.DataOutA), 4'b1100);

        // Four more back-to-back collisions: CW=2 counter saturates at 3.
        idle();
        reqA = 1'b1; rwA = 1'b0; AddrA = 3'd6; DataInA = 4'b0101;
        reqB = 1'b1; rwB = 1'b0; AddrB = 3'd6; DataInB = 4'b0110;
        for (int k = 2; k <= 5; k++) begin
            step();
            check_eq($sformatf("sat_pulse_%0d", k), 32'(if2.collision), 1);
            check_eq($sformatf("sat_cnt2_%0d", k), 32'(if2.coll_count), (k > 3) ? 3 : k);
            check_eq($sformatf("sat_cnt0_%0d", k), 32'(if0.coll_count), k);
        end
        idle();
        step();
        check_eq("sat_hold", 32'(if2.coll_count), 3);

        // Reset mid-INIT: ready must take the full sweep after the second release.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("mid_ready_low", 32'(if0.readyA), 0);
        reset = 1'b1;
        reqA = 1'b1; rwA = 1'b0; AddrA = 3'd3; DataInA = 4'b1111;
        step();
        check_eq("mid_cnt_clr", 32'(if2.coll_count), 0);
        idle();
        release_and_sweep("reinit");
        read_all_zero("rezero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memoria_dp_sync.md
Name: memoria_dp_sync

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 3-bit-address / 4-bit-data dual-port memory.
- Adds:
  - a request/ready handshake per port;
  - a registered read with a valid strobe;
  - a post-reset clear sweep;
  - deterministic write-write collision arbitration with a saturating collision counter.
- Sits between the two port masters (A, B) and is the storage for the digital-systems datapath.

Parameters:
AW, 3, address width; depth = 2**AW words
DW, 4, data width
PRIO, 0, winner of write-write collision on same address (0 = port A, 1 = port B)
CW, 8, width of collision counter

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
reqA  in  1  port A request
rwA  in  1  port A mode: 1 = read, 0 = write
AddrA  in  AW  port A address
DataInA  in  DW  port A write data
readyA  out  1  port A accepts requests
DataOutA  out  DW  port A read data, registered
validA  out  1  DataOutA updated this cycle
reqB, rwB, AddrB, DataInB, readyB, DataOutB, validB  as port A, for port B
collision  out  1  one-cycle pulse: write-write same-address event
coll_count  out  CW  saturating count of collision events

Behaviour:
- Reset (synchronous, active-high; asserted at any time, including mid-INIT or mid-RUN):
  - state = INIT, clr_ptr = 0;
  - readyA = readyB = 0, validA = validB = 0;
  - DataOutA = DataOutB = 0, collision = 0, coll_count = 0;
  - a request presented while reset is high is ignored.
- FSM states:
  - INIT:
    - each cycle with reset low: mem[clr_ptr] = 0, clr_ptr increments;
    - on the cycle clr_ptr == 2**AW-1 is written, transition to RUN;
    - sweep takes exactly 2**AW cycles after reset deasserts;
    - readyA/B are 0 throughout INIT.
  - RUN:
    - readyA = readyB = 1 (registered; first high on the cycle after the last clear write);
    - stays in RUN until reset.
- Acceptance: a port operation is accepted on a clk edge where req & ready = 1. Requests while ready = 0 are dropped, with no side effects.
- Write (rw = 0): mem[Addr] = DataIn at the accepting edge. No valid pulse.
- Read (rw = 1):
  - DataOut is loaded from mem[Addr] at the accepting edge;
  - valid = 1 for exactly that following cycle → 1-cycle latency;
  - back-to-back reads produce continuous valid;
  - DataOut holds its last value when valid = 0.
- Both ports write, same address, same cycle:
  - only the PRIO port's data is stored; the other write is discarded;
  - collision = 1 the next cycle;
  - coll_count increments, saturating at 2**CW-1 (no wrap).
- Both ports write, different addresses: both stored, no collision.
- Both ports read, any addresses (including equal): both return stored data, no collision.
- One port reads and the other writes the same address in the same cycle: not a collision. Read data depends on MEM_BYPASS_EN (below).
- Address width rule: addresses index 0..2**AW-1 exactly; there is no out-of-range case.

Optional Feature:
MEM_BYPASS_EN
- Defined: a same-cycle same-address read on one port with a write on the other returns the new write data (write-first forwarding).
- Undefined: the read returns the old stored data (read-first).
- All other behaviour is identical in both builds.

Decomposition:
- Package memoria_pkg:
  - state enum {INIT, RUN};
  - RD = 1'b1 / WR = 1'b0 mode constants;
  - PRIO_A = 0 / PRIO_B = 1 constants.
- One natural sub-module, memoria_clr_fsm:
  - contains the INIT/RUN FSM and the clr_ptr counter;
  - outputs the clear-write enable, clear address, and ready.
- The storage array, arbitration and output registers stay in memoria_dp_sync.

Test Plan (AW = 3, DW = 4):
- Reset then idle:
  - readyA/B stay 0 for 8 cycles after reset release, then rise;
  - reads of addr 0..7 all return 4'b0000 with valid one cycle later.
- Write then read on opposite port:
  - A writes 4'b1001 @ 3'b010;
  - next cycle B reads @ 3'b010 → DataOutB = 4'b1001, validB = 1 for 1 cycle.
- Write-write collision, PRIO = 0:
  - A writes 4'b1001 and B writes 4'b1010, both @ 3'b010, same cycle;
  - collision pulses once, coll_count = 1;
  - subsequent read = 4'b1001.
  - Repeat with PRIO = 1 → read = 4'b1010.
- Read/write same address:
  - mem[5] = 4'b0011; A reads @5 while B writes 4'b1100 @5;
  - DataOutA = 4'b0011 without MEM_BYPASS_EN, 4'b1100 with it;
  - collision stays 0.
- Reset mid-INIT:
  - reset asserted at INIT cycle 4 for 1 cycle;
  - ready rises exactly 8 cycles after the second release;
  - all addresses read 0.
- Counter saturation (CW = 2):
  - 5 write-write collisions → coll_count = 3;
  - collision still pulses on each event.
